music_seq_player: RTL
=====================

Name: music_seq_player

Overview:
- Parametrised song player that sequences a beat-indexed tone lookup and produces the audio square wave.
- Generates the quarter-beat tick and drives beat_num to an external tone ROM (one per song); registers the returned frequency and synthesises a square wave at that frequency.
- Adds transport control (play/pause/stop), a runtime song length, loop mode, a done pulse and a silence code.
- Sits between the game FSM (control) and the audio pin / tone ROMs.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz; phase-accumulator wrap is CLK_FREQ/2.
- TICK_CYCLES, 12500000, clocks per quarter-beat tick. Default gives 8 ticks/s at 100 MHz.
- BEAT_WIDTH, 10, width of beat_num and song_len.
- TONE_WIDTH, 32, width of tone_in and tone_out.
- SILENCE_FREQ, 20000, silence threshold: tone_in >= SILENCE_FREQ or tone_in == 0 means silence. Must be < CLK_FREQ/2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- play  input  1  single-cycle pulse: start from IDLE/DONE, resume from PAUSE.
- pause  input  1  single-cycle pulse: freeze playback.
- stop  input  1  single-cycle pulse: abort to IDLE.
- loop_en  input  1  1 = wrap to beat 0 after the last beat; sampled at each tick.
- song_len  input  BEAT_WIDTH  index of the last beat; sampled at each tick.
- tone_in  input  TONE_WIDTH  frequency in Hz from the tone ROM for the current beat_num (combinational ROM).
- beat_num  output  BEAT_WIDTH  current quarter-beat index, registered.
- tone_out  output  TONE_WIDTH  registered tone currently sounding; 0 when silent.
- audio_out  output  1  square-wave audio.
- playing  output  1  high in PLAY only.
- done  output  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset (async, rst_n low): state IDLE; beat_num 0; tick counter 0; accumulator 0; tone_out 0; audio_out 0; playing 0; done 0.
- States: IDLE, PLAY, PAUSE, DONE.
- Command priority when pulses coincide: stop > pause > play.
- stop, from any state: go to IDLE. Clear beat_num, tick counter, accumulator, tone_out and audio_out on the next edge.
- play:
  - IDLE or DONE -> PLAY with beat_num 0, tick counter 0.
  - PAUSE -> PLAY with all counters kept.
  - In PLAY, play is ignored.
- pause:
  - PLAY -> PAUSE. Tick counter, beat_num and accumulator hold; audio_out forced 0 on the next edge; tone_out holds.
  - In other states, pause is ignored.
- Tick counter: in PLAY, counts 0..TICK_CYCLES-1. At the cycle where it equals TICK_CYCLES-1 (the tick), it returns to 0, and:
  - if beat_num != song_len: beat_num <= beat_num+1;
  - else if loop_en: beat_num <= 0;
  - else: state <= DONE, done pulses 1 for exactly one cycle, beat_num holds at song_len.
- Each beat lasts exactly TICK_CYCLES clocks.
- song_len = 0 is legal: a single beat, then DONE (or repeat beat 0 with loop).
- beat_num saturates at its width only through song_len; it never wraps past 2^BEAT_WIDTH-1 on its own.
- tone_out: in PLAY, registered from tone_in every cycle (one-cycle latency from a beat_num change). A silence code registers as 0.
- Square wave, in PLAY with tone_out != 0, every cycle:
  - if acc + tone_out >= CLK_FREQ/2: acc <= acc + tone_out - CLK_FREQ/2 and audio_out toggles;
  - else acc <= acc + tone_out.
  - Output frequency equals tone_out Hz exactly on average.
  - acc is 32-bit unsigned; no overflow since tone_out < CLK_FREQ/2.
- Silence (tone_out == 0), IDLE, DONE, PAUSE: audio_out 0. acc cleared in silence, IDLE and DONE; acc held in PAUSE.
- Tone change between beats does not reset acc (phase-continuous).
- DONE: tone_out 0, audio_out 0, playing 0. Waits for play or stop.
- Reset asserted mid-song: immediate return to reset values; no done pulse.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1000, TICK_CYCLES=4, SILENCE_FREQ=400, BEAT_WIDTH=4.
- Reset, then play; ROM returns 100 for all beats, song_len=15 -> beat_num advances every 4 clocks; audio_out toggles every 5 clocks (period 10); playing=1.
- song_len=2, loop_en=0, play -> beat_num 0,1,2, each for 4 clocks; then state DONE, done high for exactly 1 cycle, audio_out 0, beat_num stays 2. A later play restarts at 0.
- song_len=2, loop_en=1 -> beat_num sequence 0,1,2,0,1,2…; no done pulse.
- Pause at beat 1, tick count 2, for 20 clocks -> beat_num and audio_out (0) frozen. Play resumes, and beat 2 arrives after exactly 1 more clock at the tick boundary plus remaining count (total 4 clocks per beat preserved).
- ROM returns 400 (silence) at beat 1 -> tone_out 0 and audio_out 0 during beat 1; tone 250 at beat 2 -> audio_out toggles every 2 clocks.
- play, pause and stop in the same cycle during PLAY -> IDLE with beat_num 0. Drop rst_n mid-beat -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/music_seq_player.sv
// Song player: walks beat_num through an external tone ROM on a quarter-beat
// tick, registers the returned frequency and synthesises a square wave at that
// frequency with a phase accumulator that wraps at CLK_FREQ/2.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | stopped, counters cleared, waiting for play
// S_PLAY  | ticking beats, tone_out follows the ROM, audio running
// S_PAUSE | counters, accumulator and tone frozen, audio held low
// S_DONE  | non-looping song finished, beat_num parked on song_len
module music_seq_player #(
    parameter int unsigned CLK_FREQ     = 100000000,
    parameter int unsigned TICK_CYCLES  = 12500000,
    parameter int unsigned BEAT_WIDTH   = 10,
    parameter int unsigned TONE_WIDTH   = 32,
    parameter int unsigned SILENCE_FREQ = 20000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  play,
    input  logic                  pause,
    input  logic                  stop,
    input  logic                  loop_en,
    input  logic [BEAT_WIDTH-1:0] song_len,
    input  logic [TONE_WIDTH-1:0] tone_in,
    output logic [BEAT_WIDTH-1:0] beat_num,
    output logic [TONE_WIDTH-1:0] tone_out,
    output logic                  audio_out,
    output logic                  playing,
    output logic                  done
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [32:0]           ACC_WRAP  = 33'(CLK_FREQ / 2);
    localparam logic [TONE_WIDTH-1:0] SIL_CODE  = TONE_WIDTH'(SILENCE_FREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_WIDTH-1:0] beat_q, beat_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [31:0]           acc_q, acc_d;
    logic [TONE_WIDTH-1:0] tone_q, tone_d;
    logic                  audio_q, audio_d;
    logic                  playing_q, playing_d;
    logic                  done_q, done_d;

    logic [32:0] acc_sum;
    logic        tone_silent;
    logic        tick_hit;

    // 33-bit sum so the wrap compare never loses the carry
    assign acc_sum     = {1'b0, acc_q} + 33'(tone_q);
    assign tone_silent = (tone_in == '0) || (tone_in >= SIL_CODE);
    assign tick_hit    = (tick_q == TICK_LAST);

    // Next-state and datapath: stop beats pause beats play
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tick_d  = tick_q;
        acc_d   = acc_q;
        tone_d  = tone_q;
        audio_d = audio_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = S_IDLE;
            beat_d  = '0;
            tick_d  = '0;
            acc_d   = '0;
            tone_d  = '0;
            audio_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (play) begin
                        state_d = S_PLAY;
                        beat_d  = '0;
                        tick_d  = '0;
                        acc_d   = '0;
                        tone_d  = '0;
                        audio_d = 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (play) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        state_d = S_PAUSE;
                        audio_d = 1'b0;
                    end else begin
                        tone_d = tone_silent ? '0 : tone_in;
                        // phase accumulator runs on the tone already sounding
                        if (tone_q == '0) begin
                            acc_d   = '0;
                            audio_d = 1'b0;
                        end else if (acc_sum >= ACC_WRAP) begin
                            acc_d   = 32'(acc_sum - ACC_WRAP);
                            audio_d = ~audio_q;
                        end else begin
                            acc_d = acc_sum[31:0];
                        end
                        if (tick_hit) begin
                            tick_d = '0;
                            // '<' rather than '!=' keeps beat_num from running
                            // past song_len even if song_len shrinks mid-song
                            if (beat_q < song_len) begin
                                beat_d = beat_q + BEAT_WIDTH'(1);
                            end else if (loop_en) begin
                                beat_d = '0;
                            end else begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                tone_d  = '0;
                                acc_d   = '0;
                                audio_d = 1'b0;
                            end
                        end else begin
                            tick_d = tick_q + TICK_W'(1);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        playing_d = (state_d == S_PLAY);
    end

    // All player state in one register bank, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            tick_q    <= '0;
            acc_q     <= '0;
            tone_q    <= '0;
            audio_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tick_q    <= tick_d;
            acc_q     <= acc_d;
            tone_q    <= tone_d;
            audio_q   <= audio_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign beat_num  = beat_q;
    assign tone_out  = tone_q;
    assign audio_out = audio_q;
    assign playing   = playing_q;
    assign done      = done_q;

endmodule
